// File: rtl/wb_reg_slice_pkg.sv
// Default bus geometry shared by the Wishbone register slice and its users.
package wb_reg_slice_pkg;

    localparam int WB_DATA_WIDTH   = 32;
    localparam int WB_ADDR_WIDTH   = 32;
    localparam int WB_SELECT_WIDTH = 4;

endpackage : wb_reg_slice_pkg

// File: rtl/wb_reg_slice.sv
// Single-stage Wishbone classic register slice: one flop stage on request and response paths.
// Optional build macro WB_REG_ABORT_EN: master dropping cyc while active aborts the slave cycle.
module wb_reg_slice
    import wb_reg_slice_pkg::*;
#(
    parameter int DATA_WIDTH   = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH   = WB_ADDR_WIDTH,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   m_adr_i,
    input  logic [DATA_WIDTH-1:0]   m_dat_i,
    output logic [DATA_WIDTH-1:0]   m_dat_o,
    input  logic                    m_we_i,
    input  logic [SELECT_WIDTH-1:0] m_sel_i,
    input  logic                    m_stb_i,
    output logic                    m_ack_o,
    output logic                    m_err_o,
    output logic                    m_rty_o,
    input  logic                    m_cyc_i,

    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    output logic                    s_we_o,
    output logic [SELECT_WIDTH-1:0] s_sel_o,
    output logic                    s_stb_o,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    input  logic                    s_rty_i,
    output logic                    s_cyc_o
);

    logic [DATA_WIDTH-1:0]   r_m_dat;
    logic                    r_m_ack;
    logic                    r_m_err;
    logic                    r_m_rty;
    logic [ADDR_WIDTH-1:0]   r_s_adr;
    logic [DATA_WIDTH-1:0]   r_s_dat;
    logic                    r_s_we;
    logic [SELECT_WIDTH-1:0] r_s_sel;
    logic                    r_s_stb;
    logic                    r_s_cyc;

    logic w_active;
    logic w_slave_term;
    logic w_master_term;

    // Active state is implied by the registered slave-side strobe and cycle.
    assign w_active      = r_s_cyc & r_s_stb;
    assign w_slave_term  = s_ack_i | s_err_i | s_rty_i;
    assign w_master_term = r_m_ack | r_m_err | r_m_rty;

    // Request capture, response forwarding and hold while the slave stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_dat <= {DATA_WIDTH{1'b0}};
            r_m_ack <= 1'b0;
            r_m_err <= 1'b0;
            r_m_rty <= 1'b0;
            r_s_adr <= {ADDR_WIDTH{1'b0}};
            r_s_dat <= {DATA_WIDTH{1'b0}};
            r_s_we  <= 1'b0;
            r_s_sel <= {SELECT_WIDTH{1'b0}};
            r_s_stb <= 1'b0;
            r_s_cyc <= 1'b0;
        end else if (!w_active) begin
            r_m_dat <= {DATA_WIDTH{1'b0}};
            r_m_ack <= 1'b0;
            r_m_err <= 1'b0;
            r_m_rty <= 1'b0;
            r_s_adr <= m_adr_i;
            r_s_dat <= m_dat_i;
            r_s_sel <= m_sel_i;
            r_s_cyc <= m_cyc_i;
            // Master still sees last termination: do not reissue the same request.
            r_s_stb <= m_stb_i & ~w_master_term;
            r_s_we  <= m_we_i & ~w_master_term;
`ifdef WB_REG_ABORT_EN
        end else if (!m_cyc_i) begin
            r_s_cyc <= 1'b0;
            r_s_stb <= 1'b0;
            r_s_we  <= 1'b0;
`endif
        end else if (w_slave_term) begin
            r_m_dat <= s_dat_i;
            r_m_ack <= s_ack_i;
            r_m_err <= s_err_i;
            r_m_rty <= s_rty_i;
            r_s_stb <= 1'b0;
            r_s_we  <= 1'b0;
        end else begin
            r_m_dat <= r_m_dat;
            r_s_stb <= r_s_stb;
        end
    end

    assign m_dat_o = r_m_dat;
    assign m_ack_o = r_m_ack;
    assign m_err_o = r_m_err;
    assign m_rty_o = r_m_rty;
    assign s_adr_o = r_s_adr;
    assign s_dat_o = r_s_dat;
    assign s_we_o  = r_s_we;
    assign s_sel_o = r_s_sel;
    assign s_stb_o = r_s_stb;
    assign s_cyc_o = r_s_cyc;

endmodule : wb_reg_slice

// File: tb/tb_wb_reg_slice.sv
// Self-checking bench for wb_reg_slice: directed plan steps plus random transactions
// checked transaction-by-transaction against the expected bus behaviour.
module tb_wb_reg_slice;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] m_adr_i;
    logic [DW-1:0] m_dat_i;
    logic [DW-1:0] m_dat_o;
    logic          m_we_i;
    logic [SW-1:0] m_sel_i;
    logic          m_stb_i;
    logic          m_ack_o;
    logic          m_err_o;
    logic          m_rty_o;
    logic          m_cyc_i;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_i;
    logic [DW-1:0] s_dat_o;
    logic          s_we_o;
    logic [SW-1:0] s_sel_o;
    logic          s_stb_o;
    logic          s_ack_i;
    logic          s_err_i;
    logic          s_rty_i;
    logic          s_cyc_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_reg_slice #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_we_i(m_we_i),
        .m_sel_i(m_sel_i), .m_stb_i(m_stb_i), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .m_rty_o(m_rty_o), .m_cyc_i(m_cyc_i),
        .s_adr_o(s_adr_o), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .s_rty_i(s_rty_i), .s_cyc_o(s_cyc_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic master_idle();
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        m_we_i  = 1'b0;
        m_adr_i = $urandom;
        m_dat_i = $urandom;
        m_sel_i = 4'($urandom);
    endtask

    task automatic slave_quiet();
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        s_rty_i = 1'b0;
        s_dat_i = $urandom;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_sbus"}, {s_adr_o, s_dat_o}, 64'd0);
        chk({tag, "_rest"}, {m_dat_o, m_ack_o, m_err_o, m_rty_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o}, 64'd0);
    endtask

    // One complete master transfer; term is {rty,err,ack} driven by the slave after 'waits' stalls.
    task automatic xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                        input logic we, input int waits, input logic [2:0] term,
                        input logic [31:0] rdat);
        m_adr_i = adr; m_dat_i = dat; m_sel_i = sel; m_we_i = we;
        m_cyc_i = 1'b1; m_stb_i = 1'b1;
        slave_quiet();
        tick();
        chk("req_cyc_stb", {s_cyc_o, s_stb_o}, 64'd3);
        chk("req_adr", s_adr_o, adr);
        chk("req_dat", s_dat_o, dat);
        chk("req_sel_we", {s_sel_o, s_we_o}, {sel, we});
        chk("req_noterm", {m_rty_o, m_err_o, m_ack_o}, 64'd0);
        for (int i = 0; i < waits; i++) begin
            m_adr_i = $urandom;
            m_dat_i = $urandom;
`ifndef WB_REG_ABORT_EN
            m_cyc_i = 1'($urandom);
            m_stb_i = 1'($urandom);
`endif
            s_dat_i = $urandom;
            tick();
            chk("wait_hold", {s_adr_o, s_cyc_o, s_stb_o, s_we_o}, {adr, 1'b1, 1'b1, we});
            chk("wait_noterm", {m_rty_o, m_err_o, m_ack_o}, 64'd0);
        end
        s_dat_i = rdat;
        {s_rty_i, s_err_i, s_ack_i} = term;
        tick();
        chk("term_flags", {m_rty_o, m_err_o, m_ack_o}, term);
        chk("term_dat", m_dat_o, rdat);
        chk("term_stb_we", {s_stb_o, s_we_o}, 64'd0);
        chk("term_hold", {s_cyc_o, s_adr_o}, {1'b1, adr});
        master_idle();
        slave_quiet();
        tick();
        chk("post_flags", {m_rty_o, m_err_o, m_ack_o}, 64'd0);
        chk("post_dat", m_dat_o, 64'd0);
        chk("post_cyc_stb", {s_cyc_o, s_stb_o}, 64'd0);
    endtask

    initial begin
        // Reset with live stimulus on the master side.
        rst = 1'b1;
        m_adr_i = 32'hFFFF_FFFF; m_dat_i = 32'hA5A5_A5A5; m_sel_i = 4'hF;
        m_we_i = 1'b1; m_stb_i = 1'b1; m_cyc_i = 1'b1;
        s_ack_i = 1'b1; s_err_i = 1'b1; s_rty_i = 1'b1; s_dat_i = 32'h1234_5678;
        tick();
        all_zero("rst1");
        tick();
        all_zero("rst2");
        rst = 1'b0;
        master_idle();
        slave_quiet();
        tick();

        // Write, zero wait states.
        xfer(32'h0000_0100, 32'h1122_3344, 4'hF, 1'b1, 0, 3'b001, 32'h0000_0000);
        // Read with 3 wait states.
        xfer(32'h0000_0200, 32'h0000_0000, 4'hF, 1'b0, 3, 3'b001, 32'hDEAD_BEEF);
        // Error then retry.
        xfer(32'h0000_0300, 32'h5555_AAAA, 4'h3, 1'b1, 1, 3'b010, 32'h0BAD_0BAD);
        xfer(32'h0000_0304, 32'h0000_0000, 4'hC, 1'b0, 2, 3'b100, 32'h0000_1111);

        // Back-to-back: stb held high through the ack.
        m_adr_i = 32'h0000_0400; m_dat_i = 32'hCAFE_0001; m_sel_i = 4'hF;
        m_we_i = 1'b1; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        tick();
        chk("b2b_req1", {s_adr_o, s_stb_o}, {32'h0000_0400, 1'b1});
        s_ack_i = 1'b1;
        tick();
        chk("b2b_ack1", {m_ack_o, s_stb_o}, 64'd2);
        s_ack_i = 1'b0;
        m_adr_i = 32'h0000_0404; m_dat_i = 32'hCAFE_0002;
        tick();
        chk("b2b_gap", {m_ack_o, s_stb_o, s_we_o}, 64'd0);
        tick();
        chk("b2b_req2", {s_adr_o, s_stb_o, s_we_o}, {32'h0000_0404, 1'b1, 1'b1});
        chk("b2b_dat2", s_dat_o, 32'hCAFE_0002);
        s_ack_i = 1'b1;
        tick();
        chk("b2b_ack2", {m_ack_o, s_stb_o}, 64'd2);
        master_idle();
        slave_quiet();
        tick();
        chk("b2b_done", {m_ack_o, s_cyc_o, s_stb_o}, 64'd0);

        // Reset in the middle of a transfer, with the slave acking.
        m_adr_i = 32'h0000_0500; m_dat_i = 32'h7777_8888; m_we_i = 1'b1;
        m_cyc_i = 1'b1; m_stb_i = 1'b1;
        tick();
        chk("mid_req", s_stb_o, 64'd1);
        s_ack_i = 1'b1; s_dat_i = 32'h9999_AAAA; rst = 1'b1;
        tick();
        all_zero("mid_rst");
        rst = 1'b0;
        master_idle();
        slave_quiet();
        tick();

`ifdef WB_REG_ABORT_EN
        // Abort while stalled; a late ack must not reach the master.
        m_adr_i = 32'h0000_0600; m_we_i = 1'b0; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        tick();
        chk("abort_req", {s_cyc_o, s_stb_o}, 64'd3);
        master_idle();
        tick();
        chk("abort_drop", {s_cyc_o, s_stb_o, s_we_o}, 64'd0);
        s_ack_i = 1'b1;
        tick();
        chk("abort_late_ack", {m_rty_o, m_err_o, m_ack_o}, 64'd0);
        slave_quiet();
        // Abort in the same cycle as the slave ack.
        m_adr_i = 32'h0000_0604; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        tick();
        chk("abort2_req", {s_cyc_o, s_stb_o}, 64'd3);
        master_idle();
        s_ack_i = 1'b1;
        tick();
        chk("abort2_drop", {s_cyc_o, s_stb_o, m_ack_o}, 64'd0);
        slave_quiet();
        tick();
        chk("abort2_after", {m_rty_o, m_err_o, m_ack_o}, 64'd0);
`endif

        // Random transfers, including simultaneous termination flags.
        for (int n = 0; n < 30; n++) begin
            logic [2:0] term;
            term = 3'($urandom_range(1, 7));
            xfer($urandom, $urandom, 4'($urandom), 1'($urandom), int'($urandom_range(0, 4)),
                 term, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_wb_reg_slice
